// File: rtl/dispense_pkg.sv
// Shared types and constants for the candy-dispense sequencer.
package dispense_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_STEP,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [1:0] BIN_INVALID = 2'd3;
  localparam int UNITS_W = 3;

  function automatic logic [2:0] bin_onehot(input logic [1:0] bin);
    return 3'b001 << bin;
  endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Stepper pulse train: `pulses` periods of half_cyc high then half_cyc low,
// starting the cycle after `start`; `finished` is high during the last low cycle.
module step_pulse_gen #(
  parameter int HALF_W = 13,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [HALF_W-1:0] half_cyc,
  input  logic [CNT_W-1:0]  pulses,
  output logic              stepper_step,
  output logic              finished
);

  logic              active;
  logic [HALF_W-1:0] hcnt;
  logic [CNT_W-1:0]  pcnt;

  assign finished = active && !stepper_step && (hcnt == '0) && (pcnt == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      active       <= 1'b0;
      stepper_step <= 1'b0;
      hcnt         <= '0;
      pcnt         <= '0;
    end else if (start) begin
      active       <= 1'b1;
      stepper_step <= 1'b1;
      hcnt         <= half_cyc - HALF_W'(1);
      pcnt         <= pulses - CNT_W'(1);
    end else if (active) begin
      if (hcnt != '0) begin
        hcnt <= hcnt - HALF_W'(1);
      end else if (stepper_step) begin
        stepper_step <= 1'b0;
        hcnt         <= half_cyc - HALF_W'(1);
      end else if (pcnt == '0) begin
        active <= 1'b0;
      end else begin
        // pcnt counts pulses still to come after the current one
        stepper_step <= 1'b1;
        hcnt         <= half_cyc - HALF_W'(1);
        pcnt         <= pcnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dispense_sequencer.sv
// Runs one dispense: per unit, DC bin motor, stepper feed, settle gap; reports busy/done/err.
// Optional DISPENSE_ABORT_EN adds an `abort` input that cancels a running transaction.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int unsigned MOTOR_ON_CYC   = 1_200_000,
  parameter int unsigned STEP_HALF_CYC  = 6000,
  parameter int unsigned STEPS_PER_UNIT = 200,
  parameter int unsigned SETTLE_CYC     = 120_000
) (
  input  logic       clk_x1,
  input  logic       rstn,
  input  logic       candyflag,
  input  logic [1:0] bin_sel,
  input  logic [1:0] stateamount,
`ifdef DISPENSE_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       stepper_step,
  output logic       stepper_dir,
  output logic [2:0] dcmotor
);

  localparam int unsigned MAX_A   = (MOTOR_ON_CYC > SETTLE_CYC) ? MOTOR_ON_CYC : SETTLE_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > STEP_HALF_CYC) ? MAX_A : STEP_HALF_CYC;
  localparam int TMR_W  = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
  localparam int HALF_W = $clog2(STEP_HALF_CYC + 1);
  localparam int CNT_W  = $clog2(STEPS_PER_UNIT + 1);
  localparam logic [TMR_W-1:0] MOTOR_LOAD  = TMR_W'(MOTOR_ON_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

  logic               sync1, sync2, prev;
  logic [1:0]         fill;
  logic               req;
  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [UNITS_W-1:0] units;
  logic [1:0]         bin;
  logic               step_start, step_done, gen_rstn;

  // prev is held high until the synchronizer carries real samples, so a flag
  // already high at reset release is not seen as a new request
  always_ff @(posedge clk_x1) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b1;
      fill  <= 2'b00;
    end else begin
      sync1 <= candyflag;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      prev  <= fill[1] ? sync2 : 1'b1;
    end
  end

  assign req        = sync2 && !prev;
  assign step_start = (state == S_MOTOR) && (tmr == '0);

`ifdef DISPENSE_ABORT_EN
  logic abort_hit;
  assign abort_hit = abort && (state != S_IDLE);
  assign gen_rstn  = rstn && !abort_hit;
`else
  assign gen_rstn  = rstn;
`endif

  always_ff @(posedge clk_x1) begin
    if (!rstn) begin
      state       <= S_IDLE;
      tmr         <= '0;
      units       <= '0;
      bin         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      stepper_dir <= 1'b0;
      dcmotor     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
`ifdef DISPENSE_ABORT_EN
      if (abort_hit) begin
        state       <= S_IDLE;
        tmr         <= '0;
        units       <= '0;
        busy        <= 1'b0;
        stepper_dir <= 1'b0;
        dcmotor     <= '0;
        err         <= 1'b1;
      end else begin
`else
      begin
`endif
        if (req && state != S_IDLE) err <= 1'b1;
        case (state)
          S_IDLE: begin
            if (req) begin
              if (bin_sel == BIN_INVALID) begin
                err <= 1'b1;
              end else begin
                bin     <= bin_sel;
                units   <= UNITS_W'(stateamount) + UNITS_W'(1);
                busy    <= 1'b1;
                dcmotor <= bin_onehot(bin_sel);
                tmr     <= MOTOR_LOAD;
                state   <= S_MOTOR;
              end
            end
          end
          S_MOTOR: begin
            if (tmr == '0) begin
              dcmotor     <= '0;
              stepper_dir <= 1'b1;
              state       <= S_STEP;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          S_STEP: begin
            if (step_done) begin
              stepper_dir <= 1'b0;
              tmr         <= SETTLE_LOAD;
              state       <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (tmr != '0) begin
              tmr <= tmr - TMR_W'(1);
            end else begin
              units <= units - UNITS_W'(1);
              if (units == UNITS_W'(1)) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                dcmotor <= bin_onehot(bin);
                tmr     <= MOTOR_LOAD;
                state   <= S_MOTOR;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  step_pulse_gen #(
    .HALF_W (HALF_W),
    .CNT_W  (CNT_W)
  ) u_step (
    .clk          (clk_x1),
    .rstn         (gen_rstn),
    .start        (step_start),
    .half_cyc     (HALF_W'(STEP_HALF_CYC)),
    .pulses       (CNT_W'(STEPS_PER_UNIT)),
    .stepper_step (stepper_step),
    .finished     (step_done)
  );

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with short phase parameters (21 cycles per unit).
module tb_dispense_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       candyflag = 1'b0;
  logic [1:0] bin_sel = 2'd0;
  logic [1:0] stateamount = 2'd0;
  logic       busy, done, err, stepper_step, stepper_dir;
  logic [2:0] dcmotor;
`ifdef DISPENSE_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  dispense_sequencer #(
    .MOTOR_ON_CYC   (5),
    .STEP_HALF_CYC  (2),
    .STEPS_PER_UNIT (3),
    .SETTLE_CYC     (4)
  ) dut (
    .clk_x1       (clk),
    .rstn         (rstn),
    .candyflag    (candyflag),
    .bin_sel      (bin_sel),
    .stateamount  (stateamount),
`ifdef DISPENSE_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .err          (err),
    .stepper_step (stepper_step),
    .stepper_dir  (stepper_dir),
    .dcmotor      (dcmotor)
  );

  int checks = 0;
  int errors = 0;
  int drop_at, rise_at, chg_at, rst_at, rel_at, ab_at;
  int busy_cyc, mot0, mot1, mot2, step_hi, step_rise, dir_cyc;
  int done_cnt, done_at, err_cnt, err_at, first_busy, bad, snap;
  logic prev_step;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pokes();
    drop_at = -1; rise_at = -1; chg_at = -1; rst_at = -1; rel_at = -1; ab_at = -1;
  endtask

  task automatic idle(input int n);
    candyflag = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Observe n cycles (index i = i-th posedge after the call), applying scheduled pokes.
  task automatic watch(input int n);
    busy_cyc = 0; mot0 = 0; mot1 = 0; mot2 = 0; step_hi = 0; step_rise = 0; dir_cyc = 0;
    done_cnt = 0; done_at = -1; err_cnt = 0; err_at = -1; first_busy = -1; bad = 0; snap = -1;
    prev_step = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cyc++;
        if (first_busy < 0) first_busy = i;
      end
      mot0 += int'(dcmotor[0]);
      mot1 += int'(dcmotor[1]);
      mot2 += int'(dcmotor[2]);
      if (stepper_step) step_hi++;
      if (stepper_step && !prev_step) step_rise++;
      prev_step = stepper_step;
      if (stepper_dir) dir_cyc++;
      if (done) begin done_cnt++; done_at = i; end
      if (err) begin err_cnt++; err_at = i; end
      if ((stepper_step && dcmotor != 3'b000) || !$onehot0(dcmotor)) bad++;
      if (rst_at >= 0 && i == rst_at + 1)
        snap = int'({busy, done, err, stepper_step, stepper_dir, dcmotor});
      if (i == drop_at) candyflag = 1'b0;
      if (i == rise_at) candyflag = 1'b1;
      if (i == chg_at) begin bin_sel = 2'd0; stateamount = 2'd0; end
      if (i == rst_at) rstn = 1'b0;
      if (i == rel_at) rstn = 1'b1;
`ifdef DISPENSE_ABORT_EN
      if (i == ab_at) abort = 1'b1;
      if (ab_at >= 0 && i == ab_at + 1) abort = 1'b0;
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_pokes();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_step", int'(stepper_step), 0);
    chk("rst_dir", int'(stepper_dir), 0);
    chk("rst_dcmotor", int'(dcmotor), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // single unit, bin 1
    clear_pokes(); bin_sel = 2'd1; stateamount = 2'd0; candyflag = 1'b1;
    watch(30);
    chk("one_first_busy", first_busy, 2);
    chk("one_busy_cyc", busy_cyc, 22);
    chk("one_mot1", mot1, 5);
    chk("one_mot_other", mot0 + mot2, 0);
    chk("one_step_rise", step_rise, 3);
    chk("one_step_hi", step_hi, 6);
    chk("one_dir_cyc", dir_cyc, 12);
    chk("one_done_cnt", done_cnt, 1);
    chk("one_done_at", done_at, 23);
    chk("one_err_cnt", err_cnt, 0);
    chk("one_exclusive", bad, 0);
    idle(4);

    // four units on bin 2; inputs changed mid-transaction must be ignored
    clear_pokes(); bin_sel = 2'd2; stateamount = 2'd3; candyflag = 1'b1; chg_at = 10;
    watch(95);
    chk("four_done_at", done_at, 86);
    chk("four_busy_cyc", busy_cyc, 85);
    chk("four_mot2", mot2, 20);
    chk("four_mot_other", mot0 + mot1, 0);
    chk("four_step_rise", step_rise, 12);
    chk("four_done_cnt", done_cnt, 1);
    chk("four_exclusive", bad, 0);
    idle(4);

    // invalid bin
    clear_pokes(); bin_sel = 2'd3; stateamount = 2'd1; candyflag = 1'b1;
    watch(8);
    chk("inv_err_cnt", err_cnt, 1);
    chk("inv_err_at", err_at, 2);
    chk("inv_busy_cyc", busy_cyc, 0);
    chk("inv_mot", mot0 + mot1 + mot2, 0);
    chk("inv_step_hi", step_hi, 0);
    idle(4);

    // second request edge during STEP
    clear_pokes(); bin_sel = 2'd0; stateamount = 2'd0; candyflag = 1'b1; drop_at = 4; rise_at = 10;
    watch(30);
    chk("busyreq_err_cnt", err_cnt, 1);
    chk("busyreq_err_at", err_at, 13);
    chk("busyreq_step_rise", step_rise, 3);
    chk("busyreq_done_cnt", done_cnt, 1);
    chk("busyreq_done_at", done_at, 23);
    chk("busyreq_mot0", mot0, 5);
    idle(4);

    // request edge lands in DONE
    clear_pokes(); bin_sel = 2'd1; stateamount = 2'd0; candyflag = 1'b1; drop_at = 4; rise_at = 21;
    watch(30);
    chk("indone_err_cnt", err_cnt, 1);
    chk("indone_err_at", err_at, 24);
    chk("indone_done_cnt", done_cnt, 1);
    chk("indone_busy_cyc", busy_cyc, 22);
    idle(4);

    // request edge lands in the cycle busy returns to 0
    clear_pokes(); bin_sel = 2'd1; stateamount = 2'd0; candyflag = 1'b1; drop_at = 4; rise_at = 22;
    watch(52);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_err_cnt", err_cnt, 0);
    chk("b2b_busy_cyc", busy_cyc, 44);
    chk("b2b_done_at", done_at, 46);
    chk("b2b_mot1", mot1, 10);
    idle(4);

    // reset during MOTOR, flag held high through release
    clear_pokes(); bin_sel = 2'd2; stateamount = 2'd1; candyflag = 1'b1; rst_at = 4; rel_at = 8;
    watch(30);
    chk("rstmid_outputs", snap, 0);
    chk("rstmid_busy_cyc", busy_cyc, 3);
    chk("rstmid_mot2", mot2, 3);
    chk("rstmid_done_cnt", done_cnt, 0);
    chk("rstmid_err_cnt", err_cnt, 0);
    chk("rstmid_step_hi", step_hi, 0);
    idle(4);

`ifdef DISPENSE_ABORT_EN
    // abort during first SETTLE of a two-unit transaction
    clear_pokes(); bin_sel = 2'd0; stateamount = 2'd1; candyflag = 1'b1; ab_at = 19;
    watch(40);
    chk("abort_err_cnt", err_cnt, 1);
    chk("abort_err_at", err_at, 20);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_busy_cyc", busy_cyc, 18);
    chk("abort_mot0", mot0, 5);
    idle(4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispense_sequencer.md
# dispense_sequencer

Sequences one candy-dispense transaction on the vending board. It accepts a request from the Raspberry Pi (the candy flag, bin select and amount) and runs the selected DC bin motor, then the stepper feed, then a settle gap, once per unit. It reports busy/done/error back to the Pi. It sits between the Pi GPIO pins and the stepper/DC motor pins at the top level, and owns those motor outputs exclusively.

## Interface
- `MOTOR_ON_CYC`, 1_200_000: cycles the selected DC motor runs per unit (100 ms at 12 MHz).
- `STEP_HALF_CYC`, 6000: cycles per half-period of a stepper step pulse.
- `STEPS_PER_UNIT`, 200: step pulses issued per unit.
- `SETTLE_CYC`, 120_000: idle cycles after the stepper phase of each unit.
- `clk_x1`  in  1  12 MHz system clock (the only clock).
- `rstn`  in  1  reset; synchronous, active-low.
- `candyflag`  in  1  dispense request from the Pi; asynchronous level; a rising edge is a request.
- `bin_sel`  in  2  bin index: 0–2 select `dcmotor[0..2]`; 3 is invalid.
- `stateamount`  in  2  amount code; units = `stateamount + 1` (1–4).
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle pulse when a transaction completes.
- `err`  out  1  one-cycle pulse when a request is rejected.
- `stepper_step`  out  1  stepper step pulse.
- `stepper_dir`  out  1  stepper direction; 1 = feed.
- `dcmotor`  out  3  one-hot DC bin motor enables.

## Operation
- `candyflag` passes through a 2-flop synchronizer, then a rising-edge detector. Holding the level high produces exactly one request.
- FSM states: IDLE, MOTOR, STEP, SETTLE, DONE.
- IDLE, on request edge:
  - `bin_sel == 3`: pulse `err`, stay in IDLE, no motion.
  - Otherwise: latch `bin_sel` and units (`stateamount + 1`, 3-bit counter), go to MOTOR.
- MOTOR: `dcmotor[bin] = 1` for exactly `MOTOR_ON_CYC` cycles, then go to STEP.
- STEP:
  - `stepper_dir = 1`.
  - Issue `STEPS_PER_UNIT` pulses, each high `STEP_HALF_CYC` cycles then low `STEP_HALF_CYC` cycles.
  - After the last low half, go to SETTLE.
- SETTLE:
  - All motor outputs 0 for `SETTLE_CYC` cycles, then decrement the unit count.
  - Count nonzero: go to MOTOR. Count zero: go to DONE.
- DONE: `done = 1` for one cycle, then go to IDLE.
- A request edge in any state other than IDLE is not queued, does not disturb the transaction, and pulses `err` for one cycle.
- `dcmotor` is one-hot or zero at all times. `dcmotor` and `stepper_step` are never active in the same cycle.
- `busy` is 1 in MOTOR, STEP, SETTLE and DONE.
- One shared down-counter times all phases. Its width is `$clog2` of the largest cycle parameter. The step counter is `$clog2(STEPS_PER_UNIT+1)` bits.
- The latched `bin_sel` and amount are used for the whole transaction. Input changes mid-transaction are ignored.

## Timing
- Reset values: all outputs 0; FSM in IDLE; synchronizer flops 0; all counters 0.
- Reset mid-operation: all outputs are 0 after the first clock edge with `rstn` low. No transaction resumes after reset.
- Request latency: `candyflag` rises before edge k. The request is accepted at edge k+2. `busy` and `dcmotor` are high after edge k+2.
- Cycle counts:
  - One unit = `MOTOR_ON_CYC + 2*STEP_HALF_CYC*STEPS_PER_UNIT + SETTLE_CYC` cycles.
  - `done` rises the cycle after the last SETTLE cycle.
  - `busy` falls one cycle after `done`.
- Back-to-back: a request edge detected in the cycle `busy` returns to 0 is accepted.
- Edge arriving exactly in DONE: rejected with `err`.

## Configuration
- `DISPENSE_ABORT_EN` defined:
  - Adds input port `abort` (1 bit, synchronous level, from the top level).
  - `abort` high in any non-IDLE state forces IDLE at the next edge, with all motor outputs 0 and counters cleared.
  - `done` is not pulsed on abort. `err` pulses once.
- `DISPENSE_ABORT_EN` undefined: the `abort` port and its logic do not exist. A transaction always runs to completion.

## Structure
- `dispense_pkg` holds:
  - the FSM state enum;
  - the `BIN_INVALID = 2'd3` constant;
  - the units-width localparam.
- Sub-module `step_pulse_gen`:
  - Inputs: start, half-period count, pulse count.
  - Outputs: `stepper_step` and a one-cycle `finished`.
  - Instanced once; the FSM waits in STEP for `finished`.
- The synchronizer and edge detector are inline in `dispense_sequencer`.

## Test plan
Parameters for all scenarios: `MOTOR_ON_CYC=5`, `STEP_HALF_CYC=2`, `STEPS_PER_UNIT=3`, `SETTLE_CYC=4`, giving 21 cycles per unit.
- **Single unit.** `bin_sel=1`, `stateamount=0`, `candyflag` rises → `dcmotor=3'b010` for 5 cycles, then 3 step pulses (2 high / 2 low), then 4 idle cycles, then `done` for 1 cycle. `busy` is high for 22 cycles in total.
- **Four units.** `bin_sel=2`, `stateamount=3` → exactly 4 MOTOR phases on `dcmotor[2]` and 12 step pulses in total. `done` arrives 84 cycles after accept.
- **Invalid bin.** `bin_sel=3` → one `err` pulse; `busy`, `dcmotor` and `stepper_step` stay 0.
- **Request while busy.** A second edge during STEP → `err` pulses once, the step count is unchanged, and only one `done` occurs.
- **Reset and held flag.** `rstn` low during MOTOR → all outputs 0 at the next edge. `candyflag` held high through reset release → no new request.
- **Abort (only with `DISPENSE_ABORT_EN`).** `abort` during SETTLE → IDLE next cycle, `err` pulses, no `done`.
